// File: rtl/sha_nonce_scheduler.sv
// sha_nonce_scheduler
// Sequences a pipelined sha_block across an inclusive nonce range, one nonce per clock.
// Tracks the hashes still in flight, compares each returned hash against a target, captures
// the first hit, drains the pipeline and then pulses done.
//
// Ports
//   clk, reset          single clock; synchronous active-low reset
//   start, abort        job control (start honoured in IDLE, abort honoured in RUN)
//   nonce_start/end     inclusive nonce range, wraps mod 2^32
//   target              hit when sha_H <= target (unsigned)
//   sha_en, sha_nonce   issue strobe and nonce to the sha_block
//   sha_en_next,
//   sha_nonce_out,
//   sha_H               result strobe, carried nonce and hash from the sha_block
//   busy, done          job status (busy in RUN/DRAIN, done 1-cycle pulse at end of job)
//   found, found_nonce,
//   found_hash          first-hit capture, held until the next accepted start
//   aborted             job ended by abort, held until the next accepted start
//   hash_count          results received this job
module sha_nonce_scheduler #(
    parameter int unsigned MAX_INFLIGHT = 256,
    parameter bit          STOP_ON_FIND = 1'b1,
    parameter int unsigned WORD_S       = 32,
    parameter int unsigned H_SIZE       = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_S-1:0] nonce_start,
    input  logic [WORD_S-1:0] nonce_end,
    input  logic [H_SIZE-1:0] target,
    output logic              sha_en,
    output logic [WORD_S-1:0] sha_nonce,
    input  logic              sha_en_next,
    input  logic [WORD_S-1:0] sha_nonce_out,
    input  logic [H_SIZE-1:0] sha_H,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [WORD_S-1:0] found_nonce,
    output logic [H_SIZE-1:0] found_hash,
    output logic              aborted,
    output logic [31:0]       hash_count
);

    localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t            state_q, state_d;
    logic [WORD_S-1:0] cur_q;
    logic [WORD_S-1:0] end_q;
    logic [H_SIZE-1:0] target_q;
    logic [CntW-1:0]   inflight_q;
    logic              hit;

    assign hit = sha_en_next && (sha_H <= target_q);

    always_comb begin
        state_d   = state_q;
        sha_en    = 1'b0;
        sha_nonce = cur_q;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                sha_en = 1'b1;
                busy   = 1'b1;
                // The nonce issued this cycle still counts even when stopping.
                if (cur_q == end_q || abort || (STOP_ON_FIND && hit)) state_d = StDrain;
            end
            StDrain: begin
                busy = 1'b1;
                if (inflight_q == '0 && !sha_en_next) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            end_q       <= '0;
            target_q    <= '0;
            inflight_q  <= '0;
            found       <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
            aborted     <= 1'b0;
            hash_count  <= '0;
        end else begin
            state_q <= state_d;

            // Issue and return in the same cycle leave the count unchanged; a stray return
            // with nothing in flight is dropped rather than underflowing.
            if (sha_en && !sha_en_next) begin
                inflight_q <= inflight_q + CntW'(1);
            end else if (!sha_en && sha_en_next && inflight_q != '0) begin
                inflight_q <= inflight_q - CntW'(1);
            end

            if (state_q == StIdle) begin
                if (start) begin
                    cur_q       <= nonce_start;
                    end_q       <= nonce_end;
                    target_q    <= target;
                    found       <= 1'b0;
                    found_nonce <= '0;
                    found_hash  <= '0;
                    aborted     <= 1'b0;
                    hash_count  <= '0;
                end
            end else begin
                if (state_q == StRun) begin
                    cur_q <= cur_q + WORD_S'(1);
                    if (abort) aborted <= 1'b1;
                end
                if (sha_en_next) begin
                    hash_count <= hash_count + 32'd1;
                    if (hit && !found) begin
                        found       <= 1'b1;
                        found_nonce <= sha_nonce_out;
                        found_hash  <= sha_H;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Bench for sha_nonce_scheduler: a stub sha pipeline returns each result 9 cycles after its
// issue cycle (done lands 10 cycles after the last issue). A job-level model predicts how many
// nonces get issued, which hit is captured and when done fires; a per-cycle compare process
// checks the strobes against that prediction.
module tb_sha_nonce_scheduler;

    localparam int LAT = 9;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic [255:0] target;
    logic         sha_en;
    logic [31:0]  sha_nonce;
    logic         sha_en_next;
    logic [31:0]  sha_nonce_out;
    logic [255:0] sha_H;
    logic         busy;
    logic         done;
    logic         found;
    logic [31:0]  found_nonce;
    logic [255:0] found_hash;
    logic         aborted;
    logic [31:0]  hash_count;

    sha_nonce_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .nonce_start  (nonce_start),
        .nonce_end    (nonce_end),
        .target       (target),
        .sha_en       (sha_en),
        .sha_nonce    (sha_nonce),
        .sha_en_next  (sha_en_next),
        .sha_nonce_out(sha_nonce_out),
        .sha_H        (sha_H),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .found_nonce  (found_nonce),
        .found_hash   (found_hash),
        .aborted      (aborted),
        .hash_count   (hash_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Programmable hash: 0 for the selected nonce, otherwise a nonzero pattern.
    logic        hit_en = 1'b0;
    logic [31:0] hit_nonce = '0;

    function automatic logic [255:0] hfun(input logic [31:0] n, input logic he,
                                          input logic [31:0] hn);
        if (he && n == hn) return '0;
        return {32'hDEAD_BEEF, 192'h0, n ^ 32'h1234_5678};
    endfunction

    // Stub pipeline
    logic [LAT-1:0] pv;
    logic [31:0]    pn [LAT];
    always @(posedge clk) begin
        if (!reset) begin
            pv <= '0;
            for (int i = 0; i < LAT; i++) pn[i] <= '0;
        end else begin
            pv    <= {pv[LAT-2:0], sha_en};
            pn[0] <= sha_nonce;
            for (int i = 1; i < LAT; i++) pn[i] <= pn[i-1];
        end
    end
    assign sha_en_next   = pv[LAT-1];
    assign sha_nonce_out = pn[LAT-1];
    assign sha_H         = hfun(pn[LAT-1], hit_en, hit_nonce);

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expectations for the job in progress, in cycles relative to the start cycle.
    bit          chk_on = 1'b0;
    int          s_cyc;
    int          exp_n;
    logic [31:0] exp_ns;
    int          done_seen;

    always @(negedge clk) begin
        int          k;
        logic [31:0] en;
        if (chk_on) begin
            k  = cyc - s_cyc;
            en = exp_ns + 32'(k - 1);
            chk("sha_en", {255'd0, sha_en}, {255'd0, (k >= 1 && k <= exp_n)});
            if (k >= 1 && k <= exp_n) chk("sha_nonce", {224'd0, sha_nonce}, {224'd0, en});
            chk("busy", {255'd0, busy}, {255'd0, (k >= 1 && k <= exp_n + 10)});
            chk("done", {255'd0, done}, {255'd0, (k == exp_n + 10)});
            if (done) done_seen++;
        end
    end

    task automatic run_job(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tg,
                           input int abort_idx, input bit pulses, input bit abort_with_start);
        logic [31:0] d;
        logic [31:0] cn;
        longint      len;
        int          n0;
        int          n;
        int          h;
        bit          ef;
        logic [31:0] efn;
        logic [255:0] efh;
        bit          ea;
        // Model: issue count is the range length cut short by abort or by a hit coming back.
        d   = ne - ns;
        len = longint'({32'd0, d}) + 1;
        n0  = int'(len);
        if (abort_idx >= 0 && abort_idx + 1 < n0) n0 = abort_idx + 1;
        h = -1;
        for (int i = 0; i < n0; i++) begin
            cn = ns + 32'(i);
            if (h < 0 && hfun(cn, hit_en, hit_nonce) <= tg) h = i;
        end
        n = n0;
        if (h >= 0 && h + LAT + 1 < n) n = h + LAT + 1;
        ef  = (h >= 0);
        efn = ns + 32'(h);
        efh = hfun(efn, hit_en, hit_nonce);
        ea  = (abort_idx >= 0 && abort_idx < n);

        @(posedge clk); #1;
        s_cyc       = cyc;
        exp_n       = n;
        exp_ns      = ns;
        done_seen   = 0;
        chk_on      = 1'b1;
        start       = 1'b1;
        abort       = abort_with_start;
        nonce_start = ns;
        nonce_end   = ne;
        target      = tg;
        for (int k = 1; k <= n + 11; k++) begin
            @(posedge clk); #1;
            start       = 1'b0;
            nonce_start = ns;
            abort       = (k == abort_idx + 1) || (pulses && k == n + 3);
            if (pulses && (k == 2 || k == n + 5)) begin
                start       = 1'b1;
                nonce_start = ns + 32'd500;
            end
        end
        @(negedge clk);
        chk_on = 1'b0;
        abort  = 1'b0;
        chk("hash_count", {224'd0, hash_count}, {224'd0, 32'(n)});
        chk("found", {255'd0, found}, {255'd0, ef});
        if (ef) begin
            chk("found_nonce", {224'd0, found_nonce}, {224'd0, efn});
            chk("found_hash", found_hash, efh);
        end
        chk("aborted", {255'd0, aborted}, {255'd0, ea});
        chk("done_pulses", 256'(done_seen), 256'd1);
        chk("inflight", 256'(dut.inflight_q), 256'd0);
    endtask

    logic [255:0] ones;
    logic [255:0] h0;

    initial begin
        ones        = '1;
        h0          = {32'hDEAD_BEEF, 192'h0, 32'h1234_5678};
        reset       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        nonce_start = '0;
        nonce_end   = '0;
        target      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sha_en", {255'd0, sha_en}, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_done", {255'd0, done}, 256'd0);
        chk("rst_found", {255'd0, found}, 256'd0);
        chk("rst_aborted", {255'd0, aborted}, 256'd0);
        chk("rst_hash_count", {224'd0, hash_count}, 256'd0);
        reset = 1'b1;

        // 1: every hash hits; stop point lies beyond the 4-nonce range.
        run_job(32'd0, 32'd3, ones, -1, 1'b0, 1'b0);
        chk("t1_found_nonce", {224'd0, found_nonce}, 256'd0);
        chk("t1_found_hash", found_hash, h0);
        chk("t1_hash_count", {224'd0, hash_count}, 256'd4);

        // 2: target 0 never hit.
        run_job(32'd0, 32'd99, '0, -1, 1'b0, 1'b0);
        chk("t2_found", {255'd0, found}, 256'd0);
        chk("t2_hash_count", {224'd0, hash_count}, 256'd100);

        // 3: wrap through 0xFFFFFFFF; abort together with start is ignored.
        run_job(32'hFFFF_FFFE, 32'h1, '0, -1, 1'b0, 1'b1);
        chk("t3_hash_count", {224'd0, hash_count}, 256'd4);
        chk("t3_aborted", {255'd0, aborted}, 256'd0);

        // 4: hit on nonce 5 stops issuing at nonce 14.
        hit_en    = 1'b1;
        hit_nonce = 32'd5;
        run_job(32'd0, 32'd1000, '0, -1, 1'b0, 1'b0);
        chk("t4_found_nonce", {224'd0, found_nonce}, 256'd5);
        chk("t4_found_hash", found_hash, 256'd0);
        chk("t4_hash_count", {224'd0, hash_count}, 256'd15);
        hit_en = 1'b0;

        // 5: abort in RUN cycle 3; stray start/abort pulses in RUN and DRAIN.
        run_job(32'd0, 32'd1000, '0, 3, 1'b1, 1'b0);
        chk("t5_aborted", {255'd0, aborted}, 256'd1);
        chk("t5_hash_count", {224'd0, hash_count}, 256'd4);

        // 6: reset with 5 nonces in flight, then a fresh job.
        @(posedge clk); #1;
        start       = 1'b1;
        nonce_start = 32'd0;
        nonce_end   = 32'd1000;
        target      = ones;
        repeat (6) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("t6_pre_busy", {255'd0, busy}, 256'd1);
        chk("t6_pre_inflight", 256'(dut.inflight_q), 256'd5);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("t6_sha_en", {255'd0, sha_en}, 256'd0);
        chk("t6_busy", {255'd0, busy}, 256'd0);
        chk("t6_found", {255'd0, found}, 256'd0);
        chk("t6_hash_count", {224'd0, hash_count}, 256'd0);
        chk("t6_inflight", 256'(dut.inflight_q), 256'd0);
        reset = 1'b1;
        run_job(32'd0, 32'd3, ones, -1, 1'b0, 1'b0);
        chk("t6_job_found_nonce", {224'd0, found_nonce}, 256'd0);
        chk("t6_job_hash_count", {224'd0, hash_count}, 256'd4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
